// File: rtl/alu_seq_pkg.sv
// Shared types and ALU opcodes for the multi-byte ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SHL = 3'd2,
    OP_SHR = 3'd3,
    OP_CMP = 3'd4
  } seq_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [4:0] ALU_ADD = 5'b01101;
  localparam logic [4:0] ALU_SLC = 5'b10100;
  localparam logic [4:0] ALU_SRC = 5'b10010;
  localparam logic [4:0] ALU_CMP = 5'b00101;
  localparam logic [4:0] ALU_NOP = 5'b00000;

  // SHR and CMP walk from the most significant byte downwards.
  function automatic logic msb_first(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/alu_mbyte_seq.sv
// Multi-byte ADD/SUB/SHL/SHR/CMP sequencer driving a shared 8-bit ALU, one byte per cycle.
// Optional macro ALU_MBYTE_SEQ_CMP_EARLY_EN: CMP stops at the first unequal byte.
module alu_mbyte_seq
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int LENW   = $clog2(NBYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [LENW-1:0]       len,
  input  logic [8*NBYTES-1:0]   opa,
  input  logic [8*NBYTES-1:0]   opb,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_o,
  output logic                  zero_o,
  output logic                  gt_o,
  output logic                  lt_o,
  output logic [4:0]            alu_op,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_ci,
  input  logic [7:0]            alu_rslt,
  input  logic                  alu_co,
  input  logic                  alu_eq,
  input  logic                  alu_gt,
  input  logic                  alu_lt
);

  localparam int IDXW = $clog2(NBYTES);
  localparam logic [LENW-1:0] LEN_ONE = LENW'(1);
  localparam logic [LENW-1:0] LEN_MAX = LENW'(NBYTES);
  localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);

  state_e                   r_state;
  logic [2:0]               r_op;
  logic [LENW-1:0]          r_len;
  logic [IDXW-1:0]          r_idx;
  logic [NBYTES-1:0][7:0]   r_opa;
  logic [NBYTES-1:0][7:0]   r_opb;
  logic [NBYTES-1:0][7:0]   r_result;
  logic                     r_carry;
  logic                     r_cmp_ne;
  logic                     r_cmp_gt;
  logic                     r_cmp_lt;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_carry_o;
  logic                     r_zero_o;
  logic                     r_gt_o;
  logic                     r_lt_o;

  logic [LENW-1:0]          w_len_eff;
  logic [IDXW-1:0]          w_start_idx;
  logic [IDXW-1:0]          w_last_idx;
  logic                     w_is_last;
  logic                     w_early;
  logic                     w_finish;
  logic [NBYTES-1:0][7:0]   w_result_nxt;
  logic                     w_zero;
  logic                     w_gt_fin;
  logic                     w_lt_fin;
  logic [4:0]               w_alu_op;
  logic [7:0]               w_alu_a;
  logic [7:0]               w_alu_b;
  logic                     w_alu_ci;

  // Effective length: 0 runs one byte, oversize requests clamp to the operand width.
  always_comb begin
    w_len_eff = len;
    if (len == {LENW{1'b0}}) begin
      w_len_eff = LEN_ONE;
    end else if (len > LEN_MAX) begin
      w_len_eff = LEN_MAX;
    end else begin
      w_len_eff = len;
    end
  end

  assign w_start_idx = msb_first(op) ? IDXW'(w_len_eff - LEN_ONE) : {IDXW{1'b0}};
  assign w_last_idx  = msb_first(r_op) ? {IDXW{1'b0}} : IDXW'(r_len - LEN_ONE);
  assign w_is_last   = (r_idx == w_last_idx);

`ifdef ALU_MBYTE_SEQ_CMP_EARLY_EN
  assign w_early = (r_op == OP_CMP) && !alu_eq;
`else
  assign w_early = 1'b0;
`endif

  assign w_finish = w_is_last || w_early;

  // ALU request for the current byte; the bus is idle outside RUN so the parent may share the ALU.
  always_comb begin
    w_alu_op = ALU_NOP;
    w_alu_a  = 8'h00;
    w_alu_b  = 8'h00;
    w_alu_ci = 1'b0;
    if (r_state == RUN) begin
      case (r_op)
        OP_ADD: begin
          w_alu_op = ALU_ADD;
          w_alu_a  = r_opa[r_idx];
          w_alu_b  = r_opb[r_idx];
          w_alu_ci = r_carry;
        end
        OP_SUB: begin
          w_alu_op = ALU_ADD;
          w_alu_a  = r_opa[r_idx];
          w_alu_b  = ~r_opb[r_idx];
          w_alu_ci = r_carry;
        end
        OP_SHL: begin
          w_alu_op = ALU_SLC;
          w_alu_a  = r_opa[r_idx];
          w_alu_ci = r_carry;
        end
        OP_SHR: begin
          w_alu_op = ALU_SRC;
          w_alu_a  = r_opa[r_idx];
          w_alu_ci = r_carry;
        end
        OP_CMP: begin
          w_alu_op = ALU_CMP;
          w_alu_a  = r_opa[r_idx];
          w_alu_b  = r_opb[r_idx];
        end
        default: begin
          w_alu_op = ALU_NOP;
        end
      endcase
    end else begin
      w_alu_op = ALU_NOP;
    end
  end

  // Result as it will look after this edge, so zero_o sees the final byte.
  always_comb begin
    w_result_nxt        = r_result;
    w_result_nxt[r_idx] = alu_rslt;
    w_zero              = (w_result_nxt == {(8*NBYTES){1'b0}});
  end

  // Compare flags come from the most significant unequal byte, which may be the current one.
  always_comb begin
    w_gt_fin = 1'b0;
    w_lt_fin = 1'b0;
    if (r_cmp_ne) begin
      w_gt_fin = r_cmp_gt;
      w_lt_fin = r_cmp_lt;
    end else begin
      w_gt_fin = !alu_eq && alu_gt;
      w_lt_fin = !alu_eq && alu_lt;
    end
  end

  // Sequencer FSM with byte index, carry chain and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_op      <= 3'd0;
      r_len     <= {LENW{1'b0}};
      r_idx     <= {IDXW{1'b0}};
      r_opa     <= {(8*NBYTES){1'b0}};
      r_opb     <= {(8*NBYTES){1'b0}};
      r_result  <= {(8*NBYTES){1'b0}};
      r_carry   <= 1'b0;
      r_cmp_ne  <= 1'b0;
      r_cmp_gt  <= 1'b0;
      r_cmp_lt  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_carry_o <= 1'b0;
      r_zero_o  <= 1'b0;
      r_gt_o    <= 1'b0;
      r_lt_o    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op      <= op;
            r_len     <= w_len_eff;
            r_opa     <= opa;
            r_opb     <= opb;
            r_idx     <= w_start_idx;
            r_result  <= {(8*NBYTES){1'b0}};
            r_carry   <= (op == OP_SUB);
            r_cmp_ne  <= 1'b0;
            r_cmp_gt  <= 1'b0;
            r_cmp_lt  <= 1'b0;
            r_carry_o <= 1'b0;
            r_zero_o  <= 1'b0;
            r_gt_o    <= 1'b0;
            r_lt_o    <= 1'b0;
            r_busy    <= 1'b1;
            if (op > 3'd4) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (r_op == OP_CMP) begin
            if (!alu_eq && !r_cmp_ne) begin
              r_cmp_ne <= 1'b1;
              r_cmp_gt <= alu_gt;
              r_cmp_lt <= alu_lt;
            end
          end else begin
            r_result <= w_result_nxt;
            r_carry  <= alu_co;
          end
          if (w_finish) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            if (r_op == OP_CMP) begin
              r_carry_o <= 1'b0;
              r_zero_o  <= !r_cmp_ne && alu_eq;
              r_gt_o    <= w_gt_fin;
              r_lt_o    <= w_lt_fin;
            end else begin
              r_carry_o <= alu_co;
              r_zero_o  <= w_zero;
              r_gt_o    <= 1'b0;
              r_lt_o    <= 1'b0;
            end
          end else begin
            r_idx <= msb_first(r_op) ? (r_idx - IDX_ONE) : (r_idx + IDX_ONE);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign carry_o = r_carry_o;
  assign zero_o  = r_zero_o;
  assign gt_o    = r_gt_o;
  assign lt_o    = r_lt_o;
  assign alu_op  = w_alu_op;
  assign alu_a   = w_alu_a;
  assign alu_b   = w_alu_b;
  assign alu_ci  = w_alu_ci;

endmodule

// File: tb/tb_alu_mbyte_seq.sv
// Scoreboard bench for alu_mbyte_seq with a behavioural 8-bit ALU beside it.
module tb_alu_mbyte_seq;
  import alu_seq_pkg::*;

  localparam int NB = 4;
  localparam int LW = $clog2(NB + 1);

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [2:0]      op;
  logic [LW-1:0]   len;
  logic [8*NB-1:0] opa, opb;
  logic            busy, done, carry_o, zero_o, gt_o, lt_o;
  logic [8*NB-1:0] result;
  logic [4:0]      alu_op;
  logic [7:0]      alu_a, alu_b, alu_rslt;
  logic            alu_ci, alu_co, alu_eq, alu_gt, alu_lt;

  typedef struct {
    logic [31:0] res;
    logic        c, z, g, l;
    int          lat;
    int          k;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;
  int   cyc     = 0;

  alu_mbyte_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .len(len),
    .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
    .carry_o(carry_o), .zero_o(zero_o), .gt_o(gt_o), .lt_o(lt_o),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
    .alu_rslt(alu_rslt), .alu_co(alu_co), .alu_eq(alu_eq),
    .alu_gt(alu_gt), .alu_lt(alu_lt)
  );

  // Behavioural ALU: add with carry, rotate through carry, unsigned compare.
  always_comb begin
    alu_rslt = 8'h00;
    alu_co   = 1'b0;
    alu_eq   = 1'b0;
    alu_gt   = 1'b0;
    alu_lt   = 1'b0;
    case (alu_op)
      5'b01101: {alu_co, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_ci};
      5'b10100: begin alu_rslt = {alu_a[6:0], alu_ci}; alu_co = alu_a[7]; end
      5'b10010: begin alu_rslt = {alu_ci, alu_a[7:1]}; alu_co = alu_a[0]; end
      5'b00101: begin
        alu_eq = (alu_a == alu_b);
        alu_gt = (alu_a > alu_b);
        alu_lt = (alu_a < alu_b);
      end
      default: alu_rslt = 8'h00;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expectation and compares all outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        n_done++;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
        end else begin
          e = q.pop_front();
          check({e.name, "_result"}, result, e.res);
          check({e.name, "_carry"}, carry_o, e.c);
          check({e.name, "_zero"}, zero_o, e.z);
          check({e.name, "_gt"}, gt_o, e.g);
          check({e.name, "_lt"}, lt_o, e.l);
          check({e.name, "_latency"}, cyc - e.k + 1, e.lat);
        end
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] o, input logic [LW-1:0] l,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                       input logic ec, input logic ez, input logic eg, input logic el,
                       input int elat, input bit expect_done);
    exp_t e;
    @(negedge clk);
    op = o; len = l; opa = a; opb = b; start = 1'b1;
    if (expect_done) begin
      e.res = er; e.c = ec; e.z = ez; e.g = eg; e.l = el;
      e.lat = elat; e.k = cyc + 1; e.name = name;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    opa = $urandom();
    opb = $urandom();
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got busy=%0b pending=%0d, expected idle", name, busy, q.size());
      q.delete();
    end
  endtask

  int cmp_lat;
  int d0;

  initial begin
`ifdef ALU_MBYTE_SEQ_CMP_EARLY_EN
    cmp_lat = 4;
`else
    cmp_lat = 5;
`endif
    rst_n = 1'b0; start = 1'b0; op = 3'd0; len = '0; opa = '0; opb = '0;
    #1;
    check("rst_result", result, 64'h0);
    check("rst_flags", {busy, done, carry_o, zero_o, gt_o, lt_o}, 64'h0);
    check("rst_alu", {alu_op, alu_a, alu_b, alu_ci}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue("add4", OP_ADD, 3'd4, 32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1);
    wait_drain("add4");
    check("idle_alu", {alu_op, alu_a, alu_b, alu_ci}, 64'h0);

    issue("sub_borrow", OP_SUB, 3'd4, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1);
    wait_drain("sub_borrow");
    issue("sub_eq", OP_SUB, 3'd4, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 5, 1'b1);
    wait_drain("sub_eq");

    issue("shl2", OP_SHL, 3'd2, 32'h5566_8081, 32'hDEAD_BEEF, 32'h0000_0102, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    wait_drain("shl2");
    issue("shr2", OP_SHR, 3'd2, 32'hAB00_0181, 32'hDEAD_BEEF, 32'h0000_00C0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    wait_drain("shr2");

    issue("cmp_gt", OP_CMP, 3'd4, 32'h1234_5678, 32'h1234_0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, cmp_lat, 1'b1);
    wait_drain("cmp_gt");
    issue("cmp_eq", OP_CMP, 3'd4, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5, 1'b1);
    wait_drain("cmp_eq");
    issue("cmp_lt", OP_CMP, 3'd2, 32'hFF00_0010, 32'h0000_0020, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1);
    wait_drain("cmp_lt");

    issue("len0", OP_ADD, 3'd0, 32'h0000_00FF, 32'h0000_0001, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b1);
    wait_drain("len0");
    issue("len_clamp", OP_ADD, 3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 5, 1'b1);
    wait_drain("len_clamp");
    issue("reserved", 3'd5, 3'd4, 32'h1234_5678, 32'h1111_1111, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    wait_drain("reserved");

    // A start pulse while busy must not launch a second operation.
    d0 = n_done;
    issue("busy_add", OP_ADD, 3'd4, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1);
    @(negedge clk);
    op = OP_SUB; len = 3'd2; opa = 32'h0000_0077; opb = 32'h0000_0011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("busy_add");
    repeat (4) @(negedge clk);
    check("busy_start_done_count", n_done - d0, 1);

    // Reset mid-RUN aborts with everything cleared and no done.
    issue("abort", OP_ADD, 3'd4, 32'h0101_0101, 32'h0101_0101, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_result", result, 64'h0);
    check("abort_flags", {busy, done, carry_o, zero_o, gt_o, lt_o}, 64'h0);
    check("abort_alu", {alu_op, alu_a, alu_b, alu_ci}, 64'h0);
    d0 = n_done;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    issue("post_abort", OP_ADD, 3'd2, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    wait_drain("post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_mbyte_seq.md
Name: alu_mbyte_seq

Overview:
- Sequencer that runs multi-byte ADD, SUB, shift-left, shift-right and compare operations on the shared 8-bit ALU, one byte per cycle.
- Carry is chained between bytes in an internal register.
- Sits beside the ALU in the datapath; the parent muxes ALU inputs to this block while busy is high.
- The ALU is not instantiated here; this block drives ALUOp/inA/inB/c_i and samples rslt/c_o/equal/gt/lt.

Parameters:
- NBYTES, 4: maximum operand width in bytes (2..8).
- LENW, $clog2(NBYTES+1): width of the len input.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  3  seq_op_e: ADD=0, SUB=1, SHL=2, SHR=3, CMP=4; 5..7 reserved
- len  input  LENW  byte count; 0 treated as 1, values >NBYTES clamped to NBYTES
- opa  input  8*NBYTES  operand A, byte 0 = LSB
- opb  input  8*NBYTES  operand B; ignored for SHL/SHR
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse in DONE
- result  output  8*NBYTES  result register
- carry_o  output  1  final carry (ADD), not-borrow (SUB), last shifted-out bit (SHL/SHR)
- zero_o  output  1  all result bytes zero (ADD/SUB/SHL/SHR); equal (CMP)
- gt_o, lt_o  output  1  unsigned compare result, CMP only; 0 otherwise
- alu_op  output  5  ALUOp to ALU
- alu_a, alu_b  output  8  inA/inB to ALU
- alu_ci  output  1  c_i to ALU
- alu_rslt  input  8  ALU rslt
- alu_co, alu_eq, alu_gt, alu_lt  input  1  ALU c_o/equal/gt/lt

Behaviour:
- Reset (async, rst_n=0): state=IDLE. result, carry_o, zero_o, gt_o, lt_o, done, busy and the carry register all 0. alu_op=5'b00000, alu_a/alu_b/alu_ci=0. Reset mid-operation aborts; no done is issued.
- IDLE:
  - start=1 latches op, effective len, opa, opb.
  - Clears result and carry register; carry register = 1 for SUB.
  - Byte index = 0 (ADD/SUB/SHL) or len-1 (SHR/CMP).
  - Next state RUN.
  - Reserved op: go straight to DONE with all outputs 0.
- RUN: one byte per cycle. ALU outputs are combinational from the latched operands at the current index. Each rising edge writes alu_rslt into result byte[idx], updates the carry register from alu_co, and steps idx.
  - ADD: alu_op=5'b01101, a=A[i], b=B[i], ci=carry.
  - SUB: alu_op=5'b01101 (ADD), b=~B[i], ci=carry (initially 1). Final carry=1 means no borrow.
  - SHL: alu_op=5'b10100, ci=carry (initially 0), LSB first.
  - SHR: alu_op=5'b10010, ci=carry (initially 0), MSB first.
  - CMP: alu_op=5'b00101, MSB first. result unchanged (0). First byte with alu_eq=0 latches gt/lt. If all bytes are equal, zero_o=1.
  - After the last byte, go to DONE.
- DONE: done=1 for one cycle. carry_o, zero_o, gt_o and lt_o update on entry and hold until the next start. Next state IDLE.
- Latency: start sampled at edge k; done high during cycle k+len+1. A new start is accepted the cycle after DONE.
- start while busy is ignored (not queued). opa/opb changes after the start edge have no effect.
- Result bytes at index >= len read 0.
- len=NBYTES wrap: idx never leaves 0..len-1.
- ALU outputs in IDLE/DONE are zero. The parent may use the ALU freely whenever busy=0.

Optional Feature:
- Macro: ALU_MBYTE_SEQ_CMP_EARLY_EN.
- Defined: CMP leaves RUN on the first unequal byte. Latency = k+m+1, where m = bytes examined.
- Undefined: CMP always scans len bytes. Fixed latency; flags still come from the most significant unequal byte.

Decomposition:
- Package alu_seq_pkg holds:
  - seq_op_e enum.
  - ALU opcode localparams: ALU_ADD=5'b01101, ALU_SLC=5'b10100, ALU_SRC=5'b10010, ALU_CMP=5'b00101, ALU_NOP=5'b00000.
  - state_e {IDLE, RUN, DONE}.
- No sub-module; a single FSM plus index counter is sufficient.
- The testbench instantiates alu alongside this block.

Test Plan:
1. NBYTES=4, ADD len=4, opa=0x00FFFFFF, opb=0x00000001 -> result=0x01000000, carry_o=0, zero_o=0, done at k+5.
2. SUB len=4, opa=0x00000000, opb=0x00000001 -> result=0xFFFFFFFF, carry_o=0 (borrow). Then opa=5, opb=5 -> result=0, zero_o=1, carry_o=1.
3. SHL len=2, opa=0x8081 -> result=0x0102, carry_o=1. SHR len=2, opa=0x0181 -> result=0x00C0, carry_o=1.
4. CMP len=4, opa=0x12345678, opb=0x12340000 -> gt_o=1, lt_o=0, zero_o=0. Done at k+4 with EARLY_EN (bytes 3,2,1 examined), at k+5 without.
5. start pulsed during RUN -> ignored, one done. rst_n low mid-RUN -> all outputs 0 immediately, IDLE, no done; next start completes normally.
6. len=0, ADD opa=0xFF, opb=0x01 -> treated as len=1: result=0x00000000, carry_o=1, zero_o=1, done at k+2.
